siso_seq: RTL and testbench
===========================

# siso_seq

Shift-sequencing controller for the serial-in/serial-out flip-flop chain. It accepts a parallel word over a valid/ready handshake and drives it LSB-first into the chain head, one bit per enabled cycle. It flushes the chain for DEPTH extra cycles, samples the chain tail, and reassembles the returning bits into a parallel word. It sits between the host logic and the shift chain, and it is the only driver of the chain's data input and shift enable.

## Interface
Parameters:
- WIDTH, 8: bits per transfer word.
- DEPTH, 4: number of flip-flop stages in the external chain; its value is 1 or greater.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- clr  input  1  asynchronous, active-low reset; forces reset state immediately and is released synchronously by the environment.
- start_valid  input  1  host has a word to send.
- start_ready  output  1  controller can accept a word; high only in IDLE.
- tx_data  input  WIDTH  word to serialize; sampled only on an accepted handshake.
- sdo  output  1  serial data to the chain head (stage 0 d input).
- sen  output  1  shift enable to the chain; the chain advances one stage per clk edge only while sen=1.
- sdi  input  1  serial data from the chain tail (stage DEPTH-1 q output).
- rx_data  output  WIDTH  reassembled word; holds its value until the next completion.
- rx_valid  output  1  one-cycle pulse: rx_data is new.
- busy  output  1  high in SHIFT and DONE.

## Operation
- The controller has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - start_ready=1, sen=0, sdo=0.
  - A transfer is accepted when start_valid=1 and start_ready=1 at a clk edge.
  - On acceptance: tx_data is latched into tx_shift, the cycle counter cnt is set to 0, and the state goes to SHIFT.
- **SHIFT**
  - sen=1 every cycle.
  - sdo=tx_shift[0].
  - At each edge, tx_shift shifts right with zero fill. After WIDTH cycles, sdo is therefore 0 for the DEPTH flush cycles.
  - At each edge where cnt is DEPTH or greater, sdi is captured: rx_shift <= {sdi, rx_shift[WIDTH-1:1]}. This places bit cnt-DEPTH at the LSB-first position.
  - cnt increments each cycle. At the edge where cnt = WIDTH+DEPTH-1, rx_data <= the final rx_shift value (including that edge's sdi) and the state goes to DONE.
- **DONE**
  - rx_valid=1 for exactly this one cycle. sen=0.
  - The state goes to IDLE on the next edge.
- Counter width is ceil(log2(WIDTH+DEPTH+1)). cnt never wraps within a transfer.
- start_valid is ignored while busy=1. tx_data changes while busy have no effect.
- Reset (clr=0), at any time including mid-SHIFT:
  - state=IDLE, cnt=0, tx_shift=0, rx_shift=0.
  - rx_data=0, rx_valid=0, sdo=0, sen=0, busy=0, start_ready=1.
  - The partial transfer is discarded, and no rx_valid is produced for it.
  - Chain contents after reset are the environment's concern.

## Timing
- Let cycle 0 be the acceptance cycle.
- sen is high in cycles 1 through WIDTH+DEPTH, which is exactly WIDTH+DEPTH cycles.
- sdo in cycle 1+k equals tx_data[k] for k < WIDTH, and 0 afterwards.
- sdi is sampled in cycles 1+DEPTH through WIDTH+DEPTH.
- rx_valid is asserted in cycle WIDTH+DEPTH+1. Latency from acceptance to rx_valid is WIDTH+DEPTH+1 cycles.
- start_ready returns high in cycle WIDTH+DEPTH+2.
- The minimum spacing between accepted starts is WIDTH+DEPTH+2 cycles.
- All outputs are registered or decoded directly from the state register. There is no combinational path from sdi or start_valid to any output.

## Test plan
Use WIDTH=8 and DEPTH=4, with an ideal 4-stage chain model clocked by clk and enabled by sen.
- Loopback 0xA5:
  - sdo over the 12 sen cycles is 1,0,1,0,0,1,0,1,0,0,0,0.
  - rx_valid is high exactly 13 cycles after acceptance, with rx_data=0xA5.
- Walking ones: send 0x01, 0x80 and 0xFF in turn. Each returns an identical rx_data, with sen high exactly 12 cycles per transfer.
- Fault model: force sdi=1 throughout → rx_data=0xFF. Force sdi=0 throughout → rx_data=0x00.
- Hold start_valid=1 continuously with tx_data changing every cycle:
  - Accepts occur every 14 cycles.
  - Each rx_data equals the tx_data present at its acceptance edge.
  - start_ready is low between accepts.
- Reset during transfer: assert clr=0 in the 6th sen cycle of 0x3C.
  - All outputs go to reset values immediately, with no rx_valid.
  - After release, a new 0x5A transfer returns 0x5A. The chain is pre-flushed by the model.
- After 0x5A completes, idle for 20 cycles with no start → rx_data stays 0x5A, sen=0, rx_valid=0.

Source files
------------

// File: rtl/siso_seq_if.sv
// Host handshake and shift-chain signals for the SISO sequencer.
// The master modport is the environment: host logic plus the chain tail.
interface siso_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] tx_data;
  logic             sdo;
  logic             sen;
  logic             sdi;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  modport master (
    output start_valid,
    output tx_data,
    output sdi,
    input  start_ready,
    input  sdo,
    input  sen,
    input  rx_data,
    input  rx_valid,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  tx_data,
    input  sdi,
    output start_ready,
    output sdo,
    output sen,
    output rx_data,
    output rx_valid,
    output busy
  );
endinterface

// File: rtl/siso_seq.sv
// Serialises a word LSB-first into an external DEPTH-stage flip-flop chain, flushes it,
// and reassembles the returning tail bits into rx_data.
module siso_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      clr,
  siso_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CntW-1:0] CntFirstCap = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntLast     = CntW'(WIDTH + DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  logic             accept;
  logic [WIDTH:0]   rx_cat;
  logic [WIDTH-1:0] rx_next;

  assign accept  = bus.start_valid && (state_q == StIdle);
  // New tail bit enters at the MSB so the first returning bit ends up at the LSB.
  assign rx_cat  = {bus.sdi, rx_shift_q};
  assign rx_next = rx_cat[WIDTH:1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_shift_d = bus.tx_data;
          cnt_d      = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        tx_shift_d = tx_shift_q >> 1;
        cnt_d      = cnt_q + CntW'(1);
        // The first DEPTH tail bits are stale chain contents and are not captured.
        if (cnt_q >= CntFirstCap) begin
          rx_shift_d = rx_next;
        end
        if (cnt_q == CntLast) begin
          rx_data_d = rx_next;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Outputs decode straight from registers; sdi and start_valid never reach an output.
  assign bus.start_ready = (state_q == StIdle);
  assign bus.sen         = (state_q == StShift);
  assign bus.sdo         = (state_q == StShift) && tx_shift_q[0];
  assign bus.rx_valid    = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);
  assign bus.rx_data     = rx_data_q;

`ifndef SYNTHESIS
  a_ready_not_busy: assert property (@(posedge clk) disable iff (!clr)
    bus.start_ready != bus.busy);
  a_valid_one_cycle: assert property (@(posedge clk) disable iff (!clr)
    bus.rx_valid |=> !bus.rx_valid);
  a_valid_after_shift: assert property (@(posedge clk) disable iff (!clr)
    bus.sen && (cnt_q == CntLast) |=> bus.rx_valid);
`endif

endmodule

// File: tb/tb_siso_seq.sv
// Directed bench for siso_seq with WIDTH=8, DEPTH=4 and an ideal 4-stage chain model.
module tb_siso_seq;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  siso_seq_if #(.WIDTH(8)) bus ();

  siso_seq #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  // Ideal chain: advances only while sen=1. sdi_mode 1/2 force the tail to 1/0.
  logic [3:0] chain = 4'b0000;
  int         sdi_mode = 0;
  always @(posedge clk) if (bus.sen) chain <= {chain[2:0], bus.sdo};
  assign bus.sdi = (sdi_mode == 1) ? 1'b1 : (sdi_mode == 2) ? 1'b0 : chain[3];

  int         total = 0;
  int         bad = 0;
  logic [11:0] sdo_log;
  int         sen_n;
  int         lat;
  logic [7:0] got;
  bit         tmo;

  // Starts one transfer from IDLE (called at posedge+1) and returns in the rx_valid cycle.
  task automatic xfer(input logic [7:0] d);
    sen_n = 0;
    lat = 0;
    tmo = 1'b1;
    sdo_log = '0;
    got = '0;
    bus.start_valid = 1'b1;
    bus.tx_data = d;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.tx_data = ~d;
    for (int i = 1; i <= 40; i++) begin
      if (bus.sen) begin
        if (sen_n < 12) sdo_log[sen_n] = bus.sdo;
        sen_n++;
      end
      if (bus.rx_valid) begin
        lat = i;
        got = bus.rx_data;
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    bus.start_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.start_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.start_ready); end
    total++; if (bus.sen !== 1'b0) begin bad++; $display("FAIL reset_sen got=%b want=0", bus.sen); end
    total++; if (bus.sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b want=0", bus.sdo); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", bus.rx_data); end
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    xfer(8'hA5);
    total++; if (tmo) begin bad++; $display("FAIL loop_timeout got=none want=rx_valid"); end
    total++; if (lat !== 13) begin bad++; $display("FAIL loop_latency got=%0d want=13", lat); end
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL loop_rx_data got=%h want=a5", got); end
    total++; if (sen_n !== 12) begin bad++; $display("FAIL loop_sen_cycles got=%0d want=12", sen_n); end
    total++; if (sdo_log !== 12'h0A5) begin bad++; $display("FAIL loop_sdo_seq got=%b want=000010100101", sdo_log); end
    total++; if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
      bad++; $display("FAIL loop_done_flags got busy=%b ready=%b want busy=1 ready=0", bus.busy, bus.start_ready);
    end
    @(posedge clk); #1;
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL loop_valid_pulse got=%b want=0", bus.rx_valid); end
    total++; if (bus.start_ready !== 1'b1) begin bad++; $display("FAIL loop_ready_back got=%b want=1", bus.start_ready); end
    total++; if (bus.rx_data !== 8'hA5) begin bad++; $display("FAIL loop_rx_hold got=%h want=a5", bus.rx_data); end
  endtask

  task automatic test_walking();
    logic [7:0] pats [3];
    pats[0] = 8'h01;
    pats[1] = 8'h80;
    pats[2] = 8'hFF;
    for (int p = 0; p < 3; p++) begin
      xfer(pats[p]);
      total++; if (tmo || got !== pats[p]) begin
        bad++; $display("FAIL walk_rx_data got=%h tmo=%0d want=%h", got, tmo, pats[p]);
      end
      total++; if (sen_n !== 12) begin bad++; $display("FAIL walk_sen_cycles got=%0d want=12", sen_n); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fault();
    sdi_mode = 1;
    xfer(8'h00);
    total++; if (tmo || got !== 8'hFF) begin bad++; $display("FAIL fault_sdi1 got=%h want=ff", got); end
    @(posedge clk); #1;
    sdi_mode = 2;
    xfer(8'hFF);
    total++; if (tmo || got !== 8'h00) begin bad++; $display("FAIL fault_sdi0 got=%h want=00", got); end
    sdi_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] expq [$];
    int         acc_cyc [$];
    logic [7:0] v;
    logic [7:0] e;
    int         n_rx;
    bit         drained;
    n_rx = 0;
    bus.start_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      v = 8'(c * 37 + 11);
      bus.tx_data = v;
      if (bus.start_ready) begin
        expq.push_back(v);
        acc_cyc.push_back(c);
      end
      if (bus.rx_valid) begin
        e = expq.pop_front();
        n_rx++;
        total++; if (bus.rx_data !== e) begin bad++; $display("FAIL b2b_rx_data got=%h want=%h", bus.rx_data, e); end
      end
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    total++; if (acc_cyc.size() !== 4) begin bad++; $display("FAIL b2b_accepts got=%0d want=4", acc_cyc.size()); end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      total++; if (acc_cyc[k] - acc_cyc[k-1] !== 14) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=14", acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rx_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
        n_rx++;
        total++; if (bus.rx_data !== e) begin bad++; $display("FAIL b2b_last_rx got=%h want=%h", bus.rx_data, e); end
        drained = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++; if (!drained || n_rx !== 4) begin
      bad++; $display("FAIL b2b_completions got=%0d want=4", n_rx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int spurious;
    bus.start_valid = 1'b1;
    bus.tx_data = 8'h3C;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    total++; if (bus.sen !== 1'b1) begin bad++; $display("FAIL mid_sen_before got=%b want=1", bus.sen); end
    #2 clr = 1'b0;
    #1;
    total++; if (bus.sen !== 1'b0 || bus.sdo !== 1'b0) begin
      bad++; $display("FAIL mid_chain_outs got sen=%b sdo=%b want 0 0", bus.sen, bus.sdo);
    end
    total++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
      bad++; $display("FAIL mid_flags got busy=%b ready=%b want busy=0 ready=1", bus.busy, bus.start_ready);
    end
    total++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin
      bad++; $display("FAIL mid_rx got valid=%b data=%h want 0 00", bus.rx_valid, bus.rx_data);
    end
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.rx_valid || bus.sen) spurious++;
      @(posedge clk); #1;
    end
    total++; if (spurious !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", spurious); end
    xfer(8'h5A);
    total++; if (tmo || got !== 8'h5A) begin bad++; $display("FAIL mid_after_rx got=%h want=5a", got); end
  endtask

  task automatic test_idle();
    int errs;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.rx_data !== 8'h5A || bus.sen !== 1'b0 || bus.rx_valid !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL idle_hold got=%0d bad cycles want=0", errs); end
    total++; if (bus.rx_data !== 8'h5A) begin bad++; $display("FAIL idle_rx_data got=%h want=5a", bus.rx_data); end
  endtask

  initial begin
    clr = 1'b0;
    bus.start_valid = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_loopback();
    test_walking();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
